sha2_msg_schedule: RTL and testbench

Parametrised SHA-2 message scheduler; successor to the fixed SHA-256 schedule. One build serves SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).
Accepts the 16 words of one message block over a valid/ready input, then expands the remaining words. Emits one W[t] per handshake, with its round index, to the hash core.
Both sides are back-pressured, and the block never drops or duplicates a word.

---
 rtl/sha2_pkg.sv | 47 ++++
 rtl/sha2_sigma.sv | 35 +++
 rtl/sha2_msg_schedule.sv | 161 ++++++++++++++++
 tb/tb_sha2_msg_schedule.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sha2_pkg
//  Description : Shared definitions for the SHA-2 message scheduler: mode
//                derived widths, sigma rotate/shift amounts, FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha2_pkg;

    // Width of the round index carried alongside each schedule word
    localparam int IDX_W = 7;

    // Word width for the selected mode (0 = SHA-256, 1 = SHA-512)
    function automatic int sha2_word_w(input int sha512);
        return (sha512 != 0) ? 64 : 32;
    endfunction

    // Number of schedule words per block for the selected mode
    function automatic int sha2_rounds(input int sha512);
        return (sha512 != 0) ? 80 : 64;
    endfunction

    // SHA-256 small sigma amounts
    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    // SHA-512 small sigma amounts
    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sha2_sigma.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_sigma
//  Description : Combinational SHA-2 small sigma functions. s0 is computed
//                from x_lo (W[t-15]) and s1 from x_hi (W[t-2]); the rotate and
//                shift amounts follow the selected mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter  int SHA512 = 0,
    localparam int WORD_W = sha2_word_w(SHA512)
) (
    input  logic [WORD_W-1:0] x_lo,
    input  logic [WORD_W-1:0] x_hi,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    // Rotate right by a constant amount within the word width
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    if (SHA512 != 0) begin : g_sha512
        assign s0 = rotr(x_lo, S512_S0_R1) ^ rotr(x_lo, S512_S0_R2) ^ (x_lo >> S512_S0_SH);
        assign s1 = rotr(x_hi, S512_S1_R1) ^ rotr(x_hi, S512_S1_R2) ^ (x_hi >> S512_S1_SH);
    end else begin : g_sha256
        assign s0 = rotr(x_lo, S256_S0_R1) ^ rotr(x_lo, S256_S0_R2) ^ (x_lo >> S256_S0_SH);
        assign s1 = rotr(x_hi, S256_S1_R1) ^ rotr(x_hi, S256_S1_R2) ^ (x_hi >> S256_S1_SH);
    end

endmodule
`default_nettype wire

// File: rtl/sha2_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_msg_schedule
//  Description : SHA-2 message scheduler (SHA-256 or SHA-512 per build).
//                Takes the 16 block words over valid/ready, then expands the
//                remaining words with a 16-entry sliding window. Every word is
//                emitted once, with its round index, through a registered
//                valid/ready output stage.
//                Optional macro SHA2_SCHED_ABORT_EN adds a synchronous abort
//                input that returns the block to IDLE from any state.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter  int SHA512 = 0,
    localparam int WORD_W = sha2_word_w(SHA512),
    localparam int ROUNDS = sha2_rounds(SHA512)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
`ifdef SHA2_SCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] wt,
    output logic [IDX_W-1:0]  wt_idx,
    output logic              wt_valid,
    input  logic              wt_ready,
    output logic              wt_last,
    output logic              busy
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        t_q, t_d;
    // win_q[0] holds W[t-1], win_q[15] holds W[t-16]
    logic [15:0][WORD_W-1:0] win_q, win_d;
    logic [WORD_W-1:0]       wt_q, wt_d;
    logic [IDX_W-1:0]        wt_idx_q, wt_idx_d;
    logic                    wt_valid_q, wt_valid_d;

    logic                    w_adv;
    logic                    w_abort;
    logic [WORD_W-1:0]       w_s0;
    logic [WORD_W-1:0]       w_s1;
    logic [WORD_W-1:0]       w_expand;

    // The output register may take a new word when empty or being consumed
    assign w_adv = !wt_valid_q || wt_ready;

`ifdef SHA2_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    sha2_sigma #(
        .SHA512 (SHA512)
    ) u_sigma (
        .x_lo (win_q[14]),
        .x_hi (win_q[1]),
        .s0   (w_s0),
        .s1   (w_s1)
    );

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], carries discarded
    assign w_expand = w_s1 + win_q[6] + w_s0 + win_q[15];

    // Next-state, datapath update and input handshake
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        win_d      = win_q;
        wt_d       = wt_q;
        wt_idx_d   = wt_idx_q;
        wt_valid_d = wt_valid_q;
        in_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    t_d     = '0;
                end
            end
            ST_LOAD: begin
                in_ready = w_adv && !w_abort;
                if (w_adv) begin
                    if (in_valid) begin
                        wt_d       = in_data;
                        wt_idx_d   = t_q;
                        wt_valid_d = 1'b1;
                        win_d      = {win_q[14:0], in_data};
                        t_d        = t_q + 1'b1;
                        if (t_q == IDX_W'(15)) begin
                            state_d = ST_EXPAND;
                        end
                    end else begin
                        wt_valid_d = 1'b0;
                    end
                end
            end
            ST_EXPAND: begin
                if (w_adv) begin
                    if (t_q < IDX_W'(ROUNDS)) begin
                        wt_d       = w_expand;
                        wt_idx_d   = t_q;
                        wt_valid_d = 1'b1;
                        win_d      = {win_q[14:0], w_expand};
                        t_d        = t_q + 1'b1;
                    end else begin
                        // All words produced and the last one just left
                        wt_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over start and over any handshake this cycle
        if (w_abort) begin
            state_d    = ST_IDLE;
            wt_valid_d = 1'b0;
            t_d        = '0;
            win_d      = '0;
        end
    end

    // State, window and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            win_q      <= '0;
            wt_q       <= '0;
            wt_idx_q   <= '0;
            wt_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            win_q      <= win_d;
            wt_q       <= wt_d;
            wt_idx_q   <= wt_idx_d;
            wt_valid_q <= wt_valid_d;
        end
    end

    assign wt       = wt_q;
    assign wt_idx   = wt_idx_q;
    assign wt_valid = wt_valid_q;
    assign wt_last  = wt_valid_q && (wt_idx_q == IDX_W'(ROUNDS - 1));
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha2_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_msg_schedule
//  Description : Scoreboard bench for sha2_msg_schedule. One SHA-256 and one
//                SHA-512 instance share stimulus; expected words come from a
//                reference schedule model plus hand-computed "abc" values.
//                Build with SHA2_SCHED_ABORT_EN to exercise the abort port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_msg_schedule;

    typedef struct {
        int          idx;
        logic [63:0] w;
    } exp_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    int          start_sel = 0;
    logic        in_valid  = 1'b0;
    logic [63:0] in_data   = '0;
    logic        wt_ready  = 1'b1;
    logic        abort     = 1'b0;

    logic        start0, start1;
    logic        in_ready0, in_ready1;
    logic [31:0] wt0;
    logic [63:0] wt1;
    logic [6:0]  idx0, idx1;
    logic        valid0, valid1, last0, last1, busy0, busy1;

    assign start0 = start && (start_sel == 0);
    assign start1 = start && (start_sel == 1);

    always #5 clk = ~clk;

    sha2_msg_schedule #(.SHA512(0)) dut0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start0),
`ifdef SHA2_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .in_data  (in_data[31:0]),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .wt       (wt0),
        .wt_idx   (idx0),
        .wt_valid (valid0),
        .wt_ready (wt_ready),
        .wt_last  (last0),
        .busy     (busy0)
    );

    sha2_msg_schedule #(.SHA512(1)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start1),
`ifdef SHA2_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .wt       (wt1),
        .wt_idx   (idx1),
        .wt_valid (valid1),
        .wt_ready (wt_ready),
        .wt_last  (last1),
        .busy     (busy1)
    );

    int          total = 0;
    int          bad   = 0;
    exp_t        q256[$];
    exp_t        q512[$];
    logic [63:0] blk [16];
    bit          abc_on [2];
    bit          busy_chk [2];
    bit          stall_p [2];
    logic [63:0] stall_w [2];
    int          stall_idx [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference sigma functions written as explicit bit rotations
    function automatic logic [31:0] r_s0_256(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] r_s1_256(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
    function automatic logic [63:0] r_s0_512(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction
    function automatic logic [63:0] r_s1_512(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    function automatic int qsize(input int m);
        return (m != 0) ? q512.size() : q256.size();
    endfunction
    function automatic logic cur_valid(input int m);
        return (m != 0) ? valid1 : valid0;
    endfunction
    function automatic int cur_idx(input int m);
        return (m != 0) ? int'(idx1) : int'(idx0);
    endfunction
    function automatic logic cur_busy(input int m);
        return (m != 0) ? busy1 : busy0;
    endfunction
    function automatic logic cur_inrdy(input int m);
        return (m != 0) ? in_ready1 : in_ready0;
    endfunction

    // Expand blk[] with the reference model and queue every expected word
    task automatic push_model(input int m);
        logic [63:0] w [80];
        int   n = (m != 0) ? 80 : 64;
        exp_t e;
        for (int t = 0; t < n; t++) begin
            if (t < 16)
                w[t] = blk[t];
            else if (m != 0)
                w[t] = r_s1_512(w[t-2]) + w[t-7] + r_s0_512(w[t-15]) + w[t-16];
            else
                w[t] = {32'h0, r_s1_256(w[t-2][31:0]) + w[t-7][31:0]
                              + r_s0_256(w[t-15][31:0]) + w[t-16][31:0]};
            e.idx = t;
            e.w   = w[t];
            if (m != 0) q512.push_back(e);
            else        q256.push_back(e);
        end
    endtask

    // Per-instance monitor step, evaluated on the falling edge
    task automatic mon(input int m, input logic [63:0] w, input int idx, input logic v,
                       input logic last, input logic bz, input logic ir);
        exp_t e;
        int   nr = (m != 0) ? 80 : 64;
        if (busy_chk[m]) begin
            busy_chk[m] = 0;
            chk("busy_after_last", 64'(bz), 64'd0);
        end
        if (stall_p[m]) begin
            chk("stall_wt", w, stall_w[m]);
            chk("stall_idx", 64'(idx), 64'(stall_idx[m]));
            chk("stall_valid", 64'(v), 64'd1);
        end
        stall_p[m] = 0;
        if (v && !wt_ready) begin
            stall_p[m]   = 1;
            stall_w[m]   = w;
            stall_idx[m] = idx;
            chk("in_ready_stall", 64'(ir), 64'd0);
        end
        if (v && wt_ready) begin
            if ((m != 0 && q512.size() == 0) || (m == 0 && q256.size() == 0)) begin
                chk("unexpected_word", 64'(idx), 64'hFFFF);
            end else begin
                e = (m != 0) ? q512.pop_front() : q256.pop_front();
                chk("wt", w, e.w);
                chk("wt_idx", 64'(idx), 64'(e.idx));
                chk("wt_last", 64'(last), 64'(e.idx == nr - 1));
                if (abc_on[m]) begin
                    if (m == 0 && idx == 16) chk("abc256_w16", w, 64'h61626380);
                    if (m == 0 && idx == 17) chk("abc256_w17", w, 64'h000F0000);
                    if (m == 0 && idx == 63) chk("abc256_w63", w, 64'h12B1EDEB);
                    if (m == 1 && idx == 16) chk("abc512_w16", w, 64'h6162638000000000);
                    if (m == 1 && idx == 17) chk("abc512_w17", w, 64'h00030000000000C0);
                end
                if (e.idx == nr - 1) busy_chk[m] = 1;
            end
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            mon(0, {32'h0, wt0}, int'(idx0), valid0, last0, busy0, in_ready0);
            mon(1, wt1, int'(idx1), valid1, last1, busy1, in_ready1);
        end
    end

    task automatic start_pulse(input int m);
        @(posedge clk); #1;
        start_sel = m;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_word(input int m, input logic [63:0] w);
        bit ok = 0;
        in_data  = w;
        in_valid = 1'b1;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (cur_inrdy(m)) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic feed(input int m, input bit bubble);
        for (int k = 0; k < 16; k++) begin
            if (bubble && k == 8) begin
                in_valid = 1'b0;
                start    = 1'b1;
                for (int b = 0; b < 3; b++) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("bubble_valid", 64'(cur_valid(m)), 64'd0);
                end
            end
            send_word(m, blk[k]);
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_ready(input int m);
        int stall = 0;
        bit did5 = 0, did40 = 0;
        for (int c = 0; c < 3000 && !(qsize(m) == 0 && !cur_busy(m)); c++) begin
            @(posedge clk); #1;
            if (stall > 0) begin
                stall--;
                wt_ready = 1'b0;
            end else if (!did5 && cur_valid(m) && cur_idx(m) == 5) begin
                did5 = 1; stall = 9; wt_ready = 1'b0;
            end else if (!did40 && cur_valid(m) && cur_idx(m) == 40) begin
                did40 = 1; stall = 9; wt_ready = 1'b0;
            end else begin
                wt_ready = 1'($urandom_range(0, 1));
            end
        end
        wt_ready = 1'b1;
    endtask

    task automatic wait_done(input int m);
        bit ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (qsize(m) == 0 && !cur_busy(m)) ok = 1;
        end
        if (!ok) chk("block_timeout", 64'(qsize(m)), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_block(input int m, input bit bubble, input bit bp);
        push_model(m);
        start_pulse(m);
        fork
            feed(m, bubble);
            if (bp) drive_ready(m);
        join
        wait_done(m);
    endtask

    task automatic set_abc(input int m);
        for (int k = 0; k < 16; k++) blk[k] = '0;
        blk[0]  = (m != 0) ? 64'h6162638000000000 : 64'h61626380;
        blk[15] = 64'h18;
        abc_on[0] = (m == 0);
        abc_on[1] = (m != 0);
    endtask

    task automatic wait_idx(input int target);
        bit ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(posedge clk); #1;
            if (valid0 && int'(idx0) == target) ok = 1;
        end
        if (!ok) chk("wait_idx_timeout", 64'(target), 64'hFFFF);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wt0", {32'h0, wt0}, 64'd0);
        chk("rst_idx0", 64'(idx0), 64'd0);
        chk("rst_valid0", 64'(valid0), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_in_ready0", 64'(in_ready0), 64'd0);
        chk("rst_last0", 64'(last0), 64'd0);
        chk("rst_wt1", wt1, 64'd0);
        chk("rst_valid1", 64'(valid1), 64'd0);
        reset_n = 1'b1;

        // SHA-256 "abc", no back-pressure
        set_abc(0);
        run_block(0, 0, 0);

        // SHA-512 "abc"
        set_abc(1);
        run_block(1, 0, 0);

        // SHA-256 "abc" with random and long back-pressure
        set_abc(0);
        run_block(0, 0, 1);

        // Varied block with a 3-cycle input bubble and a mid-block start
        abc_on[0] = 0; abc_on[1] = 0;
        for (int k = 0; k < 16; k++) blk[k] = {32'h0, 32'(32'h9E3779B9 * (k + 1))};
        run_block(0, 1, 0);

        // Asynchronous reset in the middle of a block
        set_abc(0);
        push_model(0);
        start_pulse(0);
        feed(0, 0);
        wait_idx(30);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_wt", {32'h0, wt0}, 64'd0);
        chk("midrst_idx", 64'(idx0), 64'd0);
        chk("midrst_valid", 64'(valid0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_last", 64'(last0), 64'd0);
        q256.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_block(0, 0, 0);

`ifdef SHA2_SCHED_ABORT_EN
        // Abort together with start at idx 20
        set_abc(0);
        push_model(0);
        start_pulse(0);
        feed(0, 0);
        wait_idx(20);
        abort     = 1'b1;
        start_sel = 0;
        start     = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_valid", 64'(valid0), 64'd0);
        abort = 1'b0;
        start = 1'b0;
        q256.delete();
        @(posedge clk); #1;
        chk("abort_start_ignored", 64'(busy0), 64'd0);
        run_block(0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
